// File: rtl/vout_timing_gen_mc_pkg.sv
// Shared defaults and timing presets for the video-out timing generator.
package vout_timing_gen_mc_pkg;

  localparam int DEF_CW  = 12;
  localparam int DEF_NCH = 6;
  localparam int DEF_LNW = 16;

  // One complete raster description; fields are wide enough for any CW used in practice.
  typedef struct packed {
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] h_total;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic [15:0] v_total;
  } timing_preset_t;

  localparam timing_preset_t PRESET_720P60 = '{
    h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220, h_total: 16'd1650,
    v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,  v_total: 16'd750};

  localparam timing_preset_t PRESET_1080P60 = '{
    h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148, h_total: 16'd2200,
    v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36,  v_total: 16'd1125};

  // Small raster for simulation: 20 pixels x 8 lines, active area starts at (8,4).
  localparam timing_preset_t PRESET_TEST_20X8 = '{
    h_fp: 16'd2, h_sync: 16'd3, h_bp: 16'd3, h_total: 16'd20,
    v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd1, v_total: 16'd8};

endpackage

// File: rtl/vout_seg_sequencer.sv
// Walks the active part of a line in fixed-length segments using a segment
// index and a down-counter, producing a one-hot (combinational) read request.
module vout_seg_sequencer
  import vout_timing_gen_mc_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int NCH = DEF_NCH
) (
  input  logic            dp_clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_v_act,
  input  logic [CW-1:0]   i_h_cnt,
  input  logic [CW+1:0]   i_hst,
  input  logic [CW-1:0]   i_seg,
  output logic [NCH-1:0]  o_rdreq
);

  localparam int SW = CW + 2;
  localparam int IW = $clog2(NCH + 1);

  logic [IW-1:0] r_idx, w_idx;
  logic [CW-1:0] r_rem, w_rem;
  logic          r_in,  w_in;
  logic [SW-1:0] w_h_x;
  logic          w_start;

  assign w_h_x   = SW'(i_h_cnt);
  assign w_start = i_run && (w_h_x == i_hst);

  // Segment position for the current pixel, derived from the previous pixel's
  // state; the run stops for good once the index passes the last channel.
  always_comb begin
    w_idx = r_idx;
    w_rem = r_rem;
    w_in  = 1'b0;
    if (w_start) begin
      w_idx = '0;
      w_rem = i_seg - CW'(1);
      w_in  = 1'b1;
    end else if (i_run && r_in && (w_h_x > i_hst)) begin
      if (r_rem == '0) begin
        w_idx = r_idx + IW'(1);
        w_rem = i_seg - CW'(1);
        w_in  = (r_idx + IW'(1)) < IW'(NCH);
      end else begin
        w_rem = r_rem - CW'(1);
        w_in  = 1'b1;
      end
    end
  end

  // Remember this pixel's segment position for the next one.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_rem <= '0;
      r_in  <= 1'b0;
    end else begin
      r_idx <= w_idx;
      r_rem <= w_rem;
      r_in  <= w_in;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_req
      assign o_rdreq[k] = w_in && i_v_act && (w_idx == IW'(k));
    end
  endgenerate

endmodule

// File: rtl/vout_timing_gen_mc.sv
// Programmable video timing generator: h/v counters, frame-synchronous shadow
// configuration with validity check, registered sync/de/strobes/line number
// and per-segment read requests for NCH line FIFOs.
module vout_timing_gen_mc
  import vout_timing_gen_mc_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int NCH = DEF_NCH,
  parameter int LNW = DEF_LNW
) (
  input  logic            dp_clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CW-1:0]   cfg_h_fp,
  input  logic [CW-1:0]   cfg_h_sync,
  input  logic [CW-1:0]   cfg_h_bp,
  input  logic [CW-1:0]   cfg_h_total,
  input  logic [CW-1:0]   cfg_v_fp,
  input  logic [CW-1:0]   cfg_v_sync,
  input  logic [CW-1:0]   cfg_v_bp,
  input  logic [CW-1:0]   cfg_v_total,
  input  logic [CW-1:0]   cfg_seg_len,
  input  logic            cfg_hs_pol,
  input  logic            cfg_vs_pol,
  input  logic            cfg_update,
  output logic            cfg_pending,
  output logic            cfg_err,
  output logic [NCH-1:0]  rdreq,
  output logic [LNW-1:0]  line_number,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic            sof,
  output logic            eol
);

  localparam int SW = CW + 2;

  logic [CW-1:0]  r_h_cnt, r_v_cnt;
  logic [CW-1:0]  r_h_fp, r_h_sync, r_h_bp, r_h_tot;
  logic [CW-1:0]  r_v_fp, r_v_sync, r_v_bp, r_v_tot;
  logic [CW-1:0]  r_seg;
  logic           r_hs_pol, r_vs_pol;
  logic           r_valid, r_pending, r_err;
  logic [NCH-1:0] r_rdreq;
  logic [LNW-1:0] r_line;
  logic           r_hs, r_vs, r_de, r_sof, r_eol;

  logic [SW-1:0]  w_c_hsum, w_c_vsum;
  logic           w_c_ok;
  logic           w_run, w_h_last, w_v_last, w_load;
  logic [SW-1:0]  w_h_x, w_v_x, w_hs_end, w_vs_end, w_hst, w_vst;
  logic           w_hs_raw, w_vs_raw, w_h_act, w_v_act;
  logic [NCH-1:0] w_rdreq;

  // Candidate config check; sums are two bits wider than the fields so they never wrap.
  assign w_c_hsum = SW'(cfg_h_fp) + SW'(cfg_h_sync) + SW'(cfg_h_bp);
  assign w_c_vsum = SW'(cfg_v_fp) + SW'(cfg_v_sync) + SW'(cfg_v_bp);
  assign w_c_ok   = (cfg_h_total >= CW'(2)) && (cfg_v_total >= CW'(2)) &&
                    (w_c_hsum < SW'(cfg_h_total)) && (w_c_vsum < SW'(cfg_v_total)) &&
                    (cfg_seg_len != '0);

  // Counters only run once a valid shadow exists; otherwise they sit idle at 0.
  assign w_run    = en && r_valid;
  assign w_h_last = (r_h_cnt == r_h_tot - CW'(1));
  assign w_v_last = (r_v_cnt == r_v_tot - CW'(1));
  assign w_load   = r_pending && ((w_run && w_h_last && w_v_last) || !w_run);

  assign w_h_x    = SW'(r_h_cnt);
  assign w_v_x    = SW'(r_v_cnt);
  assign w_hs_end = SW'(r_h_fp) + SW'(r_h_sync);
  assign w_vs_end = SW'(r_v_fp) + SW'(r_v_sync);
  assign w_hst    = w_hs_end + SW'(r_h_bp);
  assign w_vst    = w_vs_end + SW'(r_v_bp);
  assign w_hs_raw = w_run && (r_h_cnt >= r_h_fp) && (w_h_x < w_hs_end);
  assign w_vs_raw = w_run && (r_v_cnt >= r_v_fp) && (w_v_x < w_vs_end);
  assign w_h_act  = w_run && (w_h_x >= w_hst);
  assign w_v_act  = w_run && (w_v_x >= w_vst);

  vout_seg_sequencer #(.CW(CW), .NCH(NCH)) u_seg (
    .dp_clk  (dp_clk),
    .rst_n   (rst_n),
    .i_run   (w_run),
    .i_v_act (w_v_act),
    .i_h_cnt (r_h_cnt),
    .i_hst   (w_hst),
    .i_seg   (r_seg),
    .o_rdreq (w_rdreq)
  );

  // Shadow load: a rejected config keeps the old shadow and only flags the error.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_fp <= '0; r_h_sync <= '0; r_h_bp <= '0; r_h_tot <= '0;
      r_v_fp <= '0; r_v_sync <= '0; r_v_bp <= '0; r_v_tot <= '0;
      r_seg <= '0; r_hs_pol <= 1'b0; r_vs_pol <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      if (w_c_ok) begin
        r_h_fp <= cfg_h_fp; r_h_sync <= cfg_h_sync; r_h_bp <= cfg_h_bp; r_h_tot <= cfg_h_total;
        r_v_fp <= cfg_v_fp; r_v_sync <= cfg_v_sync; r_v_bp <= cfg_v_bp; r_v_tot <= cfg_v_total;
        r_seg <= cfg_seg_len; r_hs_pol <= cfg_hs_pol; r_vs_pol <= cfg_vs_pol;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end else begin
        r_err   <= 1'b1;
      end
    end
  end

  // Pending flag: a new request wins over a load in the same cycle.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n)          r_pending <= 1'b1;
    else if (cfg_update) r_pending <= 1'b1;
    else if (w_load)     r_pending <= 1'b0;
  end

  // Raster counters; wrap at the shadowed totals, forced to 0 when idle.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CW'(1);
    end
  end

  // Output registers; sync outputs idle at their inactive polarity when not running.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs <= 1'b0; r_vs <= 1'b0; r_de <= 1'b0;
      r_sof <= 1'b0; r_eol <= 1'b0;
      r_rdreq <= '0;
      r_line  <= '0;
    end else begin
      r_hs    <= w_hs_raw ~^ r_hs_pol;
      r_vs    <= w_vs_raw ~^ r_vs_pol;
      r_de    <= w_h_act && w_v_act;
      r_sof   <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
      r_eol   <= w_h_last && w_v_act;
      r_rdreq <= w_rdreq;
      if (w_v_act) r_line <= LNW'(r_v_cnt - w_vst[CW-1:0]);
    end
  end

  assign cfg_pending = r_pending;
  assign cfg_err     = r_err;
  assign rdreq       = r_rdreq;
  assign line_number = r_line;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign sof         = r_sof;
  assign eol         = r_eol;

endmodule

// File: tb/tb_vout_timing_gen_mc.sv
// Scoreboard bench for vout_timing_gen_mc on the 20x8 test raster, NCH=3.
// The stimulus process queues hand-computed expectations tagged with the clock
// count at which they must hold; the monitor compares them on falling edges.
module tb_vout_timing_gen_mc;
  import vout_timing_gen_mc_pkg::*;

  localparam int CW = 12, NCH = 3, LNW = 16;
  localparam int S_HS = 0, S_VS = 1, S_DE = 2, S_SOF = 3, S_EOL = 4,
                 S_RD = 5, S_LN = 6, S_PEND = 7, S_ERR = 8;

  typedef struct {
    int          c;
    int          sel;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, n_tot = 0, n_bad = 0, b = 0, b2 = 0;

  logic           dp_clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [CW-1:0]  cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_total;
  logic [CW-1:0]  cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_total, cfg_seg_len;
  logic           cfg_hs_pol, cfg_vs_pol, cfg_update;
  logic           cfg_pending, cfg_err, hs, vs, de, sof, eol;
  logic [NCH-1:0] rdreq;
  logic [LNW-1:0] line_number;

  vout_timing_gen_mc #(.CW(CW), .NCH(NCH), .LNW(LNW)) dut (
    .dp_clk(dp_clk), .rst_n(rst_n), .en(en),
    .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_total(cfg_h_total),
    .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_total(cfg_v_total),
    .cfg_seg_len(cfg_seg_len), .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .cfg_update(cfg_update), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .rdreq(rdreq), .line_number(line_number),
    .hs(hs), .vs(vs), .de(de), .sof(sof), .eol(eol)
  );

  initial forever #5 dp_clk = ~dp_clk;
  initial forever begin @(posedge dp_clk); cyc++; end

  function automatic logic [31:0] act(input int sel);
    case (sel)
      S_HS:    return 32'(hs);
      S_VS:    return 32'(vs);
      S_DE:    return 32'(de);
      S_SOF:   return 32'(sof);
      S_EOL:   return 32'(eol);
      S_RD:    return 32'(rdreq);
      S_LN:    return 32'(line_number);
      S_PEND:  return 32'(cfg_pending);
      S_ERR:   return 32'(cfg_err);
      default: return 'x;
    endcase
  endfunction

  task automatic ex(input int c, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.c = c; e.sel = sel; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge dp_clk); while (cyc < c);
  endtask

  task automatic ex_idle(input int c, input string nm);
    ex(c, S_HS, 0, nm); ex(c, S_VS, 0, nm); ex(c, S_DE, 0, nm); ex(c, S_SOF, 0, nm);
    ex(c, S_EOL, 0, nm); ex(c, S_RD, 0, nm); ex(c, S_LN, 0, nm);
    ex(c, S_PEND, 1, nm); ex(c, S_ERR, 0, nm);
  endtask

  // Monitor: compare every queued expectation due at this clock count.
  initial forever begin
    @(negedge dp_clk);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c == cyc) begin
        n_tot++;
        if (act(q[i].sel) !== q[i].v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d sel=%0d got=%0h want=%0h", q[i].nm, cyc, q[i].sel,
                   act(q[i].sel), q[i].v);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    cfg_h_fp    = PRESET_TEST_20X8.h_fp[CW-1:0];
    cfg_h_sync  = PRESET_TEST_20X8.h_sync[CW-1:0];
    cfg_h_bp    = PRESET_TEST_20X8.h_bp[CW-1:0];
    cfg_h_total = PRESET_TEST_20X8.h_total[CW-1:0];
    cfg_v_fp    = PRESET_TEST_20X8.v_fp[CW-1:0];
    cfg_v_sync  = PRESET_TEST_20X8.v_sync[CW-1:0];
    cfg_v_bp    = PRESET_TEST_20X8.v_bp[CW-1:0];
    cfg_v_total = PRESET_TEST_20X8.v_total[CW-1:0];
    cfg_seg_len = 12'd4;
    cfg_hs_pol  = 1'b1;
    cfg_vs_pol  = 1'b1;
    cfg_update  = 1'b0;
    en          = 1'b1;
    ex_idle(2, "reset_state");
    wait_cyc(4);
    n_tot++; if (hs !== 1'b0) begin n_bad++; $display("FAIL rst_hs got=%0b", hs); end
    n_tot++; if (vs !== 1'b0) begin n_bad++; $display("FAIL rst_vs got=%0b", vs); end
    n_tot++; if (de !== 1'b0) begin n_bad++; $display("FAIL rst_de got=%0b", de); end
    n_tot++; if (sof !== 1'b0) begin n_bad++; $display("FAIL rst_sof got=%0b", sof); end
    n_tot++; if (eol !== 1'b0) begin n_bad++; $display("FAIL rst_eol got=%0b", eol); end
    n_tot++; if (rdreq !== '0) begin n_bad++; $display("FAIL rst_rdreq got=%0h", rdreq); end
    n_tot++; if (line_number !== '0) begin n_bad++; $display("FAIL rst_ln got=%0h", line_number); end
    n_tot++; if (cfg_pending !== 1'b1) begin n_bad++; $display("FAIL rst_pend got=%0b", cfg_pending); end
    n_tot++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0b", cfg_err); end
    rst_n = 1'b1;
    b = cyc;
    // Frame 0: pixel p (= v*20+h) is visible at clock b+p+2.
    ex(b+2, S_SOF, 1, "sof_first");     ex(b+2, S_PEND, 0, "pend_clr_boot");
    ex(b+3, S_SOF, 0, "sof_one_cycle"); ex(b+3, S_HS, 0, "hs_pre");
    ex(b+4, S_HS, 1, "hs_h2");          ex(b+6, S_HS, 1, "hs_h4");
    ex(b+7, S_HS, 0, "hs_post");
    ex(b+21, S_VS, 0, "vs_v0");         ex(b+22, S_VS, 1, "vs_v1");
    ex(b+61, S_VS, 1, "vs_v2_end");     ex(b+62, S_VS, 0, "vs_v3");
    ex(b+89, S_DE, 0, "de_h7");         ex(b+89, S_RD, 0, "rd_h7");
    ex(b+90, S_DE, 1, "de_h8");         ex(b+90, S_RD, 1, "rd_h8");
    ex(b+90, S_LN, 0, "ln_v4");
    ex(b+93, S_RD, 1, "rd_h11");        ex(b+94, S_RD, 2, "rd_h12");
    ex(b+97, S_RD, 2, "rd_h15");        ex(b+98, S_RD, 4, "rd_h16");
    ex(b+100, S_EOL, 0, "eol_h18");     ex(b+101, S_RD, 4, "rd_h19");
    ex(b+101, S_EOL, 1, "eol_h19");     ex(b+101, S_DE, 1, "de_h19");
    ex(b+102, S_DE, 0, "de_v5_h0");
    ex(b+150, S_LN, 3, "ln_v7");        ex(b+162, S_SOF, 1, "sof_frame1");
    ex(b+162, S_LN, 3, "ln_hold");
    // seg=5 requested in frame 1, applies from frame 2.
    ex(b+170, S_PEND, 0, "pend_idle");  ex(b+171, S_PEND, 1, "pend_set");
    ex(b+258, S_RD, 4, "rd_seg4_kept"); ex(b+320, S_PEND, 1, "pend_before_load");
    ex(b+321, S_PEND, 0, "pend_loaded");
    ex(b+414, S_RD, 1, "seg5_h12");     ex(b+415, S_RD, 2, "seg5_h13");
    ex(b+419, S_RD, 2, "seg5_h17");     ex(b+420, S_RD, 4, "seg5_h18");
    ex(b+421, S_RD, 4, "seg5_h19");     ex(b+422, S_RD, 0, "seg5_next_line");
    // seg=3 applies from frame 3: last three pixels get no request.
    ex(b+575, S_RD, 2, "seg3_h13");     ex(b+578, S_RD, 4, "seg3_h16");
    ex(b+579, S_RD, 0, "seg3_h17");     ex(b+581, S_RD, 0, "seg3_h19");
    ex(b+581, S_DE, 1, "seg3_de_h19");
    // h_tot=24 requested at v=2 of frame 4, applies from frame 5.
    ex(b+741, S_EOL, 1, "f4_eol_h19");  ex(b+800, S_PEND, 1, "htot_pend");
    ex(b+801, S_PEND, 0, "htot_loaded"); ex(b+801, S_SOF, 0, "f4_last");
    ex(b+802, S_SOF, 1, "sof_f5");
    ex(b+917, S_RD, 4, "h24_rd_h19");   ex(b+917, S_DE, 1, "h24_de_h19");
    ex(b+917, S_EOL, 0, "h24_eol_h19"); ex(b+918, S_RD, 0, "h24_rd_h20");
    ex(b+918, S_DE, 1, "h24_de_h20");   ex(b+921, S_EOL, 1, "h24_eol_h23");
    // Invalid config at frame 5 end: error, timing kept at 24 pixels.
    ex(b+992, S_ERR, 0, "err_before");  ex(b+993, S_ERR, 1, "err_set");
    ex(b+993, S_PEND, 0, "err_pend_clr"); ex(b+993, S_SOF, 0, "f5_last");
    ex(b+994, S_SOF, 1, "sof_f6");      ex(b+1109, S_EOL, 0, "inv_eol_h19");
    ex(b+1113, S_EOL, 1, "inv_eol_h23");
    // Valid config with hs_pol=0 at frame 6 end.
    ex(b+1184, S_ERR, 1, "err_hold");   ex(b+1185, S_ERR, 0, "err_clr");
    ex(b+1186, S_SOF, 1, "sof_f7");
    ex(b+1187, S_HS, 1, "pol0_h1");     ex(b+1188, S_HS, 0, "pol0_h2");
    ex(b+1190, S_HS, 0, "pol0_h4");     ex(b+1191, S_HS, 1, "pol0_h5");
    ex_idle(b+1252, "midreset_a");      ex_idle(b+1253, "midreset_b");

    wait_cyc(b+170); cfg_seg_len = 12'd5; cfg_update = 1'b1;
    wait_cyc(b+171); cfg_update = 1'b0;
    wait_cyc(b+330); cfg_seg_len = 12'd3; cfg_update = 1'b1;
    wait_cyc(b+331); cfg_update = 1'b0;
    wait_cyc(b+682); cfg_seg_len = 12'd4; cfg_h_total = 12'd24; cfg_update = 1'b1;
    wait_cyc(b+683); cfg_update = 1'b0;
    wait_cyc(b+830); cfg_h_total = 12'd20; cfg_h_bp = 12'd15; cfg_update = 1'b1;
    wait_cyc(b+831); cfg_update = 1'b0;
    wait_cyc(b+1000); cfg_h_bp = 12'd3; cfg_hs_pol = 1'b0; cfg_update = 1'b1;
    wait_cyc(b+1001); cfg_update = 1'b0;
    wait_cyc(b+1251); rst_n = 1'b0;
    wait_cyc(b+1254); rst_n = 1'b1;
    b2 = cyc;
    ex(b2+1, S_HS, 1, "rst_hs_idle_hi"); ex(b2+1, S_PEND, 0, "rst_reload");
    ex(b2+1, S_SOF, 0, "rst_sof_wait");
    ex(b2+2, S_SOF, 1, "rst_sof");       ex(b2+2, S_HS, 1, "rst_hs_h0");
    ex(b2+2, S_VS, 0, "rst_vs_v0");      ex(b2+3, S_SOF, 0, "rst_sof_end");
    ex(b2+30, S_VS, 1, "en_vs_v1");      ex(b2+31, S_VS, 0, "en0_vs");
    ex(b2+32, S_HS, 1, "en0_hs");        ex(b2+32, S_DE, 0, "en0_de");
    ex(b2+32, S_RD, 0, "en0_rd");
    wait_cyc(b2+30); en = 1'b0;
    wait_cyc(b2+40);
    foreach (q[i]) begin
      n_tot++;
      n_bad++;
      $display("FAIL %s never_checked due=%0d", q[i].nm, q[i].c);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
